// File: rtl/fir_pkg.sv
// Shared constants, coefficients and helpers for the dual-form 6-tap FIR harness.
package fir_pkg;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int XW      = 12;
    localparam int CW      = 14;
    localparam int YW      = XW + CW;
    localparam int NTAPS   = 6;
    localparam int LATENCY = 3;

    localparam logic signed [CW-1:0] C [0:NTAPS-1] = '{
        14'sh3aa4, 14'sh1433, 14'sh0e37, 14'sh1a57, 14'sh0917, 14'sh2c1d
    };

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_t;

    // Full-precision signed product; a 12x14 product always fits in 26 bits.
    function automatic logic signed [YW-1:0] mul(input logic signed [XW-1:0] x,
                                                 input logic signed [CW-1:0] c);
        logic signed [YW-1:0] xe;
        logic signed [YW-1:0] ce;
        xe = x;
        ce = c;
        return xe * ce;
    endfunction

endpackage

// File: rtl/fir_ram.sv
// Simple single-clock RAM with a registered read port and synchronous write.
module fir_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately never reset; the storage name is relied on externally.
    reg [WIDTH-1:0] array [0:DEPTH-1];

    always @(posedge clk) begin
        if (we) begin
            array[waddr] <= wdata;
        end
        rdata <= array[raddr];
    end

endmodule

// File: rtl/top_fir_filter.sv
// Self-running harness: streams 256 samples through direct and transposed 6-tap FIRs.
module top_fir_filter
    import fir_pkg::*;
(
    input logic clk,
    input logic reset
);

    seq_state_t            state;
    logic [AW-1:0]         rd_addr;
    logic                  issue_valid;

    logic [LATENCY-2:0]    valid_pipe;
    logic [AW-1:0]         addr_pipe [0:LATENCY-2];

    logic signed [XW-1:0]  direct_x;
    logic signed [XW-1:0]  trans_x;
    logic signed [XW-1:0]  taps [0:NTAPS-2];
    logic signed [YW-1:0]  direct_sum;
    logic signed [YW-1:0]  direct_y;
    logic signed [YW-1:0]  trans_y;
    logic signed [YW-1:0]  psum [1:NTAPS-1];

    logic [YW-1:0]         unused_direct_rdata;
    logic [YW-1:0]         unused_trans_rdata;

    // One pass over the input RAMs per reset release; DONE holds until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SEQ_IDLE;
            rd_addr <= '0;
        end else begin
            case (state)
                SEQ_IDLE: state <= SEQ_RUN;
                SEQ_RUN: begin
                    if (rd_addr == AW'(DEPTH - 1)) begin
                        state <= SEQ_DONE;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: state <= SEQ_DONE;
            endcase
        end
    end

    assign issue_valid = (state == SEQ_RUN);

    // Stage 0 lines up with the RAM read data, stage 1 with the registered filter outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_pipe <= '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            valid_pipe[0] <= issue_valid;
            addr_pipe[0]  <= rd_addr;
            valid_pipe[1] <= valid_pipe[0];
            addr_pipe[1]  <= addr_pipe[0];
        end
    end

    always_comb begin
        direct_sum = mul(direct_x, C[0]);
        for (int k = 1; k < NTAPS; k++) begin
            direct_sum = direct_sum + mul(taps[k-1], C[k]);
        end
    end

    // Direct form: taps hold x[n-1]..x[n-5] while x[n] arrives from the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            direct_y <= '0;
            for (int k = 0; k < NTAPS - 1; k++) begin
                taps[k] <= '0;
            end
        end else if (valid_pipe[0]) begin
            direct_y <= direct_sum;
            taps[0]  <= direct_x;
            for (int k = 1; k < NTAPS - 1; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    // Transposed form: psum[k] carries sum of c_j*x[n-j+k] for j>=k into the next sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trans_y <= '0;
            for (int k = 1; k < NTAPS; k++) begin
                psum[k] <= '0;
            end
        end else if (valid_pipe[0]) begin
            trans_y <= mul(trans_x, C[0]) + psum[1];
            for (int k = 1; k < NTAPS - 1; k++) begin
                psum[k] <= mul(trans_x, C[k]) + psum[k+1];
            end
            psum[NTAPS-1] <= mul(trans_x, C[NTAPS-1]);
        end
    end

    fir_ram #(.WIDTH(XW), .DEPTH(DEPTH), .AW(AW)) DIRECT_INPUT_MEM (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (rd_addr),
        .rdata (direct_x)
    );

    fir_ram #(.WIDTH(XW), .DEPTH(DEPTH), .AW(AW)) TRANS_INPUT_MEM (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (rd_addr),
        .rdata (trans_x)
    );

    fir_ram #(.WIDTH(YW), .DEPTH(DEPTH), .AW(AW)) DIRECT_OUTPUT_MEM (
        .clk   (clk),
        .we    (valid_pipe[1]),
        .waddr (addr_pipe[1]),
        .wdata (direct_y),
        .raddr ('0),
        .rdata (unused_direct_rdata)
    );

    fir_ram #(.WIDTH(YW), .DEPTH(DEPTH), .AW(AW)) TRANS_OUTPUT_MEM (
        .clk   (clk),
        .we    (valid_pipe[1]),
        .waddr (addr_pipe[1]),
        .wdata (trans_y),
        .raddr ('0),
        .rdata (unused_trans_rdata)
    );

endmodule

// File: tb/tb_top_fir_filter.sv
// Self-checking bench: preloads RAMs hierarchically and compares against a convolution model.
module tb_top_fir_filter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int xd[256];
    int xt[256];
    int coef[6] = '{-1372, 5171, 3639, 6743, 2327, -5091};

    localparam logic [25:0] SENTINEL = 26'h2AAAAAA;

    always #5 clk = ~clk;

    top_fir_filter dut (
        .clk   (clk),
        .reset (reset)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain convolution with zero history before sample 0, wrapped to 26 bits.
    function automatic logic [25:0] model_y(input bit trans, input int n);
        int acc;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (n - k >= 0) begin
                acc += coef[k] * (trans ? xt[n-k] : xd[n-k]);
            end
        end
        return acc[25:0];
    endfunction

    function automatic int rand_sample();
        int v;
        v = int'($urandom_range(0, 4095));
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            dut.DIRECT_INPUT_MEM.array[i]  = 12'(xd[i]);
            dut.TRANS_INPUT_MEM.array[i]   = 12'(xt[i]);
            dut.DIRECT_OUTPUT_MEM.array[i] = SENTINEL;
            dut.TRANS_OUTPUT_MEM.array[i]  = SENTINEL;
        end
    endtask

    task automatic compare_all(input string name);
        for (int i = 0; i < 256; i++) begin
            checkOutput($sformatf("%s direct[%0d]", name, i), 32'(dut.DIRECT_OUTPUT_MEM.array[i]), 32'(model_y(1'b0, i)));
            checkOutput($sformatf("%s trans[%0d]", name, i), 32'(dut.TRANS_OUTPUT_MEM.array[i]), 32'(model_y(1'b1, i)));
        end
    endtask

    // Full run from reset: checks no writes under reset, write timing, then every entry.
    task automatic applyStimulus(input string name);
        int cyc;
        int first_w;
        int last_w;
        @(negedge clk);
        reset = 1'b0;
        preload();
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, " idle direct[0]"}, 32'(dut.DIRECT_OUTPUT_MEM.array[0]), 32'(SENTINEL));
        checkOutput({name, " idle trans[0]"}, 32'(dut.TRANS_OUTPUT_MEM.array[0]), 32'(SENTINEL));
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        first_w = -1;
        last_w = -1;
        while (last_w < 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (first_w < 0 && dut.DIRECT_OUTPUT_MEM.array[0] != SENTINEL) first_w = cyc;
            if (dut.DIRECT_OUTPUT_MEM.array[255] != SENTINEL) last_w = cyc;
        end
        checkOutput({name, " deadline"}, 32'(last_w > 0 && last_w <= 260), 32'd1);
        checkOutput({name, " span"}, 32'(last_w - first_w), 32'd255);
        repeat (4) @(posedge clk);
        #1;
        compare_all(name);
    endtask

    task automatic midstream_reset();
        logic [25:0] snap_d[256];
        logic [25:0] snap_t[256];
        int changed;
        @(negedge clk);
        reset = 1'b0;
        preload();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            snap_d[i] = dut.DIRECT_OUTPUT_MEM.array[i];
            snap_t[i] = dut.TRANS_OUTPUT_MEM.array[i];
        end
        repeat (4) @(posedge clk);
        #1;
        changed = 0;
        for (int i = 0; i < 256; i++) begin
            if (snap_d[i] != dut.DIRECT_OUTPUT_MEM.array[i]) changed++;
            if (snap_t[i] != dut.TRANS_OUTPUT_MEM.array[i]) changed++;
        end
        checkOutput("midreset writes under reset", 32'(changed), 32'd0);
        checkOutput("midreset partial written", 32'(snap_d[50] != SENTINEL), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (265) @(posedge clk);
        #1;
        compare_all("midreset");
    endtask

    initial begin
        $display("[TB] starting top_fir_filter bench");

        for (int i = 0; i < 256; i++) begin
            xd[i] = (i == 0) ? 1 : 0;
            xt[i] = xd[i];
        end
        applyStimulus("impulse");
        checkOutput("impulse direct[0] const", 32'(dut.DIRECT_OUTPUT_MEM.array[0]), 32'h3FFFAA4);
        checkOutput("impulse trans[5] const", 32'(dut.TRANS_OUTPUT_MEM.array[5]), 32'h3FFEC1D);
        checkOutput("impulse trans[3] const", 32'(dut.TRANS_OUTPUT_MEM.array[3]), 32'h0001A57);

        for (int i = 0; i < 256; i++) begin
            xd[i] = 1;
            xt[i] = 1;
        end
        applyStimulus("step");
        checkOutput("step direct[1] const", 32'(dut.DIRECT_OUTPUT_MEM.array[1]), 32'h0000ED7);
        checkOutput("step trans[4] const", 32'(dut.TRANS_OUTPUT_MEM.array[4]), 32'h000407C);
        checkOutput("step direct[200] const", 32'(dut.DIRECT_OUTPUT_MEM.array[200]), 32'h0002C99);

        for (int i = 0; i < 256; i++) begin
            xd[i] = -2048;
            xt[i] = -2048;
        end
        applyStimulus("negfs");
        checkOutput("negfs direct[5] const", 32'(dut.DIRECT_OUTPUT_MEM.array[5]), 32'h29B3800);
        checkOutput("negfs trans[255] const", 32'(dut.TRANS_OUTPUT_MEM.array[255]), 32'h29B3800);

        for (int i = 0; i < 256; i++) begin
            xd[i] = rand_sample();
            xt[i] = rand_sample();
        end
        applyStimulus("random");

        for (int i = 0; i < 256; i++) begin
            xd[i] = rand_sample();
            xt[i] = rand_sample();
        end
        midstream_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
